// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector: latches 0->1 transitions per input bit and
// serialises them round-robin onto a registered valid/ready event channel.
module edge_event_arbiter #(
   parameter int N   = 8,
   parameter int IDW = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   in,
   input  logic           evt_ready,
   input  logic           ovf_clr,
   output logic           evt_valid,
   output logic [IDW-1:0] evt_id,
   output logic [N-1:0]   pending,
   output logic [N-1:0]   overflow
);

   typedef enum logic {S_IDLE, S_OFFER} state_t;

   state_t         r_state;
   logic [N-1:0]   r_prev;
   logic [N-1:0]   r_pending;
   logic [N-1:0]   r_overflow;
   logic           r_valid;
   logic [IDW-1:0] r_id;
   logic [IDW-1:0] r_ptr;

   logic [N-1:0]   w_edge;
   logic [N-1:0]   w_take;
   logic           w_found;
   logic           w_load;
   logic [IDW-1:0] w_win;
   logic [IDW-1:0] w_ptr_nxt;

   assign w_edge = in & ~r_prev;

   // First set pending bit at or after r_ptr, wrapping modulo N.
   always_comb begin : arb
      logic [IDW-1:0] idx;
      idx     = '0;
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = IDW'((32'(r_ptr) + k) % N);
         if (!w_found && r_pending[idx]) begin
            w_found = 1'b1;
            w_win   = idx;
         end
      end
   end

   assign w_ptr_nxt = (w_win == IDW'(N - 1)) ? '0 : w_win + 1'b1;

   // A new winner is loaded from IDLE, or on a handshake while offering.
   assign w_load = w_found & ((r_state == S_IDLE) | evt_ready);
   assign w_take = w_load ? (N'(1) << w_win) : '0;

   always_ff @(posedge clk) begin
      r_prev <= in;
      if (reset) begin
         r_state    <= S_IDLE;
         r_valid    <= 1'b0;
         r_id       <= '0;
         r_ptr      <= '0;
         r_pending  <= '0;
         r_overflow <= '0;
      end else begin
         r_pending  <= (r_pending & ~w_take) | w_edge;
         // Clear first, then OR in new losses so a coincident set wins.
         r_overflow <= (ovf_clr ? '0 : r_overflow) | (w_edge & r_pending & ~w_take);
         if (w_load) begin
            r_id  <= w_win;
            r_ptr <= w_ptr_nxt;
         end
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state <= S_OFFER;
                  r_valid <= 1'b1;
               end
            end
            S_OFFER: begin
               if (evt_ready && !w_found) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign evt_valid = r_valid;
   assign evt_id    = r_id;
   assign pending   = r_pending;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed and randomized checks of edge_event_arbiter against a
// cycle-level behavioural model of the edge/pending/round-robin rules.
module tb_edge_event_arbiter;
   localparam int N   = 8;
   localparam int IDW = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   in;
   logic           evt_ready;
   logic           ovf_clr;
   logic           evt_valid;
   logic [IDW-1:0] evt_id;
   logic [N-1:0]   pending;
   logic [N-1:0]   overflow;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state
   bit   m_prev [N];
   bit   m_pend [N];
   bit   m_ovf  [N];
   bit   m_busy;
   int   m_id;
   int   m_ptr;

   edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in),
      .evt_ready (evt_ready),
      .ovf_clr   (ovf_clr),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .pending   (pending),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_pend_vec();
      logic [31:0] v = '0;
      for (int i = 0; i < N; i++) if (m_pend[i]) v = v + (32'd1 << i);
      return v;
   endfunction

   function automatic logic [31:0] m_ovf_vec();
      logic [31:0] v = '0;
      for (int i = 0; i < N; i++) if (m_ovf[i]) v = v + (32'd1 << i);
      return v;
   endfunction

   // One clock of the reference behaviour, using the inputs present at the edge.
   task automatic model_step();
      int win;
      bit e;
      if (reset) begin
         m_busy = 0; m_id = 0; m_ptr = 0;
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_ovf[i] = 0;
         end
      end else begin
         win = -1;
         if (!m_busy || evt_ready) begin
            for (int k = 0; k < N; k++) begin
               if (win < 0 && m_pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
         end
         for (int i = 0; i < N; i++) begin
            e = in[i] && !m_prev[i];
            if (ovf_clr) m_ovf[i] = 0;
            if (e && m_pend[i] && i != win) m_ovf[i] = 1;
            m_pend[i] = (m_pend[i] && i != win) || e;
         end
         if (win >= 0) begin
            m_busy = 1; m_id = win; m_ptr = (win + 1) % N;
         end else if (m_busy && evt_ready) begin
            m_busy = 0;
         end
      end
      for (int i = 0; i < N; i++) m_prev[i] = in[i];
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("model_valid", 32'(evt_valid), 32'(m_busy));
      if (m_busy) chk("model_id", 32'(evt_id), 32'(m_id));
      chk("model_pending", 32'(pending), m_pend_vec());
      chk("model_overflow", 32'(overflow), m_ovf_vec());
   endtask

   initial begin
      int nv;
      reset = 1'b1; in = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
      m_busy = 0; m_id = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) begin
         m_prev[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
      end
      tick(); tick();
      chk("rst_valid", 32'(evt_valid), 0);
      chk("rst_id", 32'(evt_id), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_overflow", 32'(overflow), 0);
      reset = 1'b0;

      // single edge
      evt_ready = 1'b1;
      tick(); tick();
      in = 8'h02;
      nv = 0;
      tick();
      chk("se_pending", 32'(pending), 32'h02);
      chk("se_nolat", 32'(evt_valid), 0);
      tick();
      chk("se_valid", 32'(evt_valid), 1);
      chk("se_id", 32'(evt_id), 1);
      nv += int'(evt_valid);
      tick(); nv += int'(evt_valid);
      tick(); nv += int'(evt_valid);
      chk("se_count", 32'(nv), 1);
      in = 8'h0E;
      tick();
      chk("se2_nolat", 32'(evt_valid), 0);
      tick();
      chk("se2_id2", 32'(evt_id), 2);
      tick();
      chk("se2_id3", 32'(evt_id), 3);
      tick();
      chk("se2_idle", 32'(evt_valid), 0);
      in = 8'h02;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("fall_noevt", 32'(evt_valid), 0);
      end

      // round-robin wrap from ptr 0
      reset = 1'b1; in = '0; tick(); reset = 1'b0;
      in = 8'hFF;
      tick();
      for (int i = 0; i < N; i++) begin
         tick();
         chk("rr0_valid", 32'(evt_valid), 1);
         chk("rr0_id", 32'(evt_id), 32'(i));
      end
      tick();
      chk("rr0_done", 32'(evt_valid), 0);

      // round-robin with ptr moved to 5 by a bit-4 event
      reset = 1'b1; in = '0; tick(); reset = 1'b0;
      in = 8'h10; tick(); tick(); tick();
      in = 8'hFF;
      tick();
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("rr5_id", 32'(evt_id), 32'((5 + i) % 8));
      end
      tick();
      chk("rr5_done", 32'(evt_valid), 0);

      // backpressure
      reset = 1'b1; in = '0; tick(); reset = 1'b0;
      evt_ready = 1'b0;
      in = 8'h48;
      tick(); tick();
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("bp_valid", 32'(evt_valid), 1);
         chk("bp_id", 32'(evt_id), 3);
         chk("bp_pending", 32'(pending), 32'h40);
      end
      evt_ready = 1'b1; tick(); evt_ready = 1'b0;
      chk("bp_next", 32'(evt_id), 6);
      tick();
      chk("bp_hold6", 32'(evt_id), 6);
      evt_ready = 1'b1; tick();
      chk("bp_drain", 32'(evt_valid), 0);

      // overflow
      evt_ready = 1'b0; in = '0; tick();
      in = 8'h04; tick(); tick();
      chk("ov_off2", 32'(evt_id), 2);
      in = 8'h05; tick();
      in = 8'h04; tick();
      in = 8'h05; tick();
      chk("ov_set", 32'(overflow), 32'h01);
      in = 8'h04;
      evt_ready = 1'b1; tick();
      chk("ov_id0", 32'(evt_id), 0);
      tick();
      chk("ov_once", 32'(evt_valid), 0);
      evt_ready = 1'b0;
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("ov_clr", 32'(overflow), 0);
      in = 8'h00; tick();
      in = 8'h04; tick(); tick();
      in = 8'h05; tick();
      in = 8'h04; tick();
      in = 8'h05; ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("ov_setwins", 32'(overflow), 32'h01);
      evt_ready = 1'b1; tick(); tick(); tick();

      // reset mid-operation
      evt_ready = 1'b0; in = '0; tick();
      in = 8'h01; tick(); tick();
      in = 8'hF1; tick();
      chk("rm_valid", 32'(evt_valid), 1);
      chk("rm_pending", 32'(pending), 32'hF0);
      reset = 1'b1; in = 8'hFF; tick(); reset = 1'b0;
      chk("rm_valid0", 32'(evt_valid), 0);
      chk("rm_id0", 32'(evt_id), 0);
      chk("rm_pend0", 32'(pending), 0);
      chk("rm_ovf0", 32'(overflow), 0);
      evt_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rm_quiet", 32'(evt_valid), 0);
      end
      in = 8'h7F; tick();
      in = 8'hFF; tick(); tick();
      chk("rm_id7", 32'(evt_id), 7);
      chk("rm_v7", 32'(evt_valid), 1);
      tick();
      chk("rm_single", 32'(evt_valid), 0);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         in        = in ^ (N'($urandom) & N'($urandom) & N'($urandom));
         evt_ready = ($urandom_range(0, 3) != 0);
         ovf_clr   = ($urandom_range(0, 15) == 0);
         reset     = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0; ovf_clr = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
